// File: rtl/bc_chain_sequencer.sv
//------------------------------------------------------------------------------
// bc_chain_sequencer
//
// Head-of-chain sequencer for the lane-to-lane broadcast operand chain that
// feeds the matmul datapath. A command supplies an element count and a tag.
// The block then streams that many 64-bit operands from the source port into
// lane 0. At most MaxOutstanding elements may be in flight. An element is in
// flight from the moment it is issued until the tail lane acknowledges it.
// Completion is reported once every issued element has been retired. A flush
// aborts issuing, but the block still collects acks for elements already in
// the chain.
//
// Parameters
//   NrLanes        lanes in the chain; caps the credit budget at 2*NrLanes
//   MaxOutstanding credit budget (elements issued but not yet retired)
//   CntWidth       width of the element counter and cmd_len_i
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   cmd_valid_i     command request
//   cmd_ready_o     command accepted when high together with cmd_valid_i
//   cmd_len_i       number of elements to broadcast
//   cmd_id_i        command tag, echoed on done_id_o
//   src_valid_i     source operand valid
//   src_ready_o     source operand consumed
//   src_data_i      source operand
//   bc_valid_o      chain head valid
//   bc_ready_i      chain head ready (from lane 0)
//   bc_data_o       chain head data
//   tail_ack_i      one-cycle pulse, tail lane retired one element
//   flush_i         abort the current command
//   done_o          one-cycle completion pulse
//   done_id_o       tag of the completed command
//   done_aborted_o  completed command was flushed
//   busy_o          sequencer is not idle
//   credit_err_o    sticky: an ack arrived while all credits were home
//------------------------------------------------------------------------------
module bc_chain_sequencer #(
    parameter int NrLanes        = 4,
    parameter int MaxOutstanding = 4,
    parameter int CntWidth       = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [CntWidth-1:0] cmd_len_i,
    input  logic [3:0]          cmd_id_i,
    input  logic                src_valid_i,
    output logic                src_ready_o,
    input  logic [63:0]         src_data_i,
    output logic                bc_valid_o,
    input  logic                bc_ready_i,
    output logic [63:0]         bc_data_o,
    input  logic                tail_ack_i,
    input  logic                flush_i,
    output logic                done_o,
    output logic [3:0]          done_id_o,
    output logic                done_aborted_o,
    output logic                busy_o,
    output logic                credit_err_o
);

    // The chain cannot hold more than two elements per lane, so the budget
    // is clamped to that. For every legal parameter set this equals
    // MaxOutstanding.
    localparam int CreditCap = (MaxOutstanding < 2 * NrLanes) ? MaxOutstanding : 2 * NrLanes;
    localparam int CredW     = $clog2(CreditCap + 1);
    localparam logic [CredW-1:0] CredMax = CredW'(CreditCap);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] issued_q, issued_d;
    logic [CntWidth-1:0] len_q, len_d;
    logic [3:0]          id_q, id_d;
    logic [CredW-1:0]    credits_q, credits_d;
    logic                aborted_q, aborted_d;
    logic                credit_err_q, credit_err_d;

    logic in_issue;
    logic issue_gate;
    logic xfer;
    logic cmd_accept;

    //--------------------------------------------------------------------------
    // Chain head handshake. Issue is allowed only in ISSUE with at least one
    // credit. A flush blocks issue in the same cycle, so nothing new enters the
    // chain once the abort is seen. src_ready_o follows the chain head's ready
    // rather than src_valid_i. This keeps the two sides of the pass-through
    // free of a combinational loop. Data is gated to zero outside ISSUE so the
    // chain never sees stale operands.
    //--------------------------------------------------------------------------
    assign in_issue    = (state_q == ISSUE);
    assign issue_gate  = in_issue & (credits_q != '0) & ~flush_i;
    assign bc_valid_o  = issue_gate & src_valid_i;
    assign src_ready_o = issue_gate & bc_ready_i;
    assign bc_data_o   = in_issue ? src_data_i : '0;
    assign xfer        = bc_valid_o & bc_ready_i;

    //--------------------------------------------------------------------------
    // Status outputs. These are decoded from registered state only, so they are
    // glitch-free and change only after a clock edge or a reset.
    //--------------------------------------------------------------------------
    assign cmd_ready_o    = (state_q == IDLE);
    assign cmd_accept     = cmd_ready_o & cmd_valid_i;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign done_id_o      = id_q;
    assign done_aborted_o = done_o & aborted_q;
    assign credit_err_o   = credit_err_q;

    //--------------------------------------------------------------------------
    // Credit accounting, active in every state. An issue and an ack in the same
    // cycle cancel out. An ack that would push the count past the budget is
    // dropped and latched as a protocol error. The tail retired something the
    // sequencer never issued, or that was issued before a reset.
    //--------------------------------------------------------------------------
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (xfer && !tail_ack_i) begin
            credits_d = credits_q - CredW'(1);
        end else if (!xfer && tail_ack_i) begin
            if (credits_q == CredMax) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CredW'(1);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Command sequencing.
    //
    // DRAIN compares against the next credit value. This lets an ack arriving
    // in the same cycle that returns the last credit move straight to DONE,
    // one cycle after that ack.
    //
    // A zero-length command skips the chain entirely and reports completion
    // one cycle after it is accepted.
    //
    // A flush during DRAIN only marks the command as aborted. Elements already
    // in flight must still be retired before the command can complete.
    //--------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        len_d     = len_q;
        id_d      = id_q;
        aborted_d = aborted_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    len_d     = cmd_len_i;
                    id_d      = cmd_id_i;
                    issued_d  = '0;
                    aborted_d = 1'b0;
                    state_d   = (cmd_len_i != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (flush_i) begin
                    aborted_d = 1'b1;
                    state_d   = DRAIN;
                end else if (xfer) begin
                    issued_d = issued_q + CntWidth'(1);
                    if (issued_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    aborted_d = 1'b1;
                end
                if (credits_d == CredMax) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State register. Reset returns every credit to the pool immediately. Acks
    // for elements issued before the reset are therefore not expected. If any
    // arrive while the pool is full, they set the error flag.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            issued_q     <= '0;
            len_q        <= '0;
            id_q         <= '0;
            credits_q    <= CredMax;
            aborted_q    <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            len_q        <= len_d;
            id_q         <= id_d;
            credits_q    <= credits_d;
            aborted_q    <= aborted_d;
            credit_err_q <= credit_err_d;
        end
    end

endmodule

// File: tb/tb_bc_chain_sequencer.sv
//------------------------------------------------------------------------------
// tb_bc_chain_sequencer
//
// Directed bench for bc_chain_sequencer with the default parameters
// (4 credits). Each scenario task runs a command through run_cmd. run_cmd
// records per-cycle observations. The task then compares these against
// hand-computed cycle numbers and values. Cycle 0 is the cycle after the
// command is accepted.
//------------------------------------------------------------------------------
module tb_bc_chain_sequencer;

    localparam logic [63:0] DBASE = 64'hA5A5_0000_0000_1000;

    logic        clk_i;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [15:0] cmd_len_i;
    logic [3:0]  cmd_id_i;
    logic        src_valid_i;
    logic        src_ready_o;
    logic [63:0] src_data_i;
    logic        bc_valid_o;
    logic        bc_ready_i;
    logic [63:0] bc_data_o;
    logic        tail_ack_i;
    logic        flush_i;
    logic        done_o;
    logic [3:0]  done_id_o;
    logic        done_aborted_o;
    logic        busy_o;
    logic        credit_err_o;

    int errors = 0;
    int checks = 0;

    // Observations recorded by run_cmd.
    logic        bcv  [64];
    logic        srdy [64];
    logic [2:0]  cred [64];
    int          xfer_cyc  [16];
    logic [63:0] xfer_data [16];
    int          n_xfer;
    int          done_cnt;
    int          done_cyc;
    logic [3:0]  done_id;
    logic        done_ab;
    logic        acc_ready;

    bc_chain_sequencer #(
        .NrLanes       (4),
        .MaxOutstanding(4),
        .CntWidth      (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_len_i     (cmd_len_i),
        .cmd_id_i      (cmd_id_i),
        .src_valid_i   (src_valid_i),
        .src_ready_o   (src_ready_o),
        .src_data_i    (src_data_i),
        .bc_valid_o    (bc_valid_o),
        .bc_ready_i    (bc_ready_i),
        .bc_data_o     (bc_data_o),
        .tail_ack_i    (tail_ack_i),
        .flush_i       (flush_i),
        .done_o        (done_o),
        .done_id_o     (done_id_o),
        .done_aborted_o(done_aborted_o),
        .busy_o        (busy_o),
        .credit_err_o  (credit_err_o)
    );

    // Free-running clock, period 10.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Returns every input to its idle value.
    task automatic idle_inputs();
        cmd_valid_i = 1'b0;
        cmd_len_i   = '0;
        cmd_id_i    = '0;
        src_valid_i = 1'b0;
        src_data_i  = '0;
        bc_ready_i  = 1'b0;
        tail_ack_i  = 1'b0;
        flush_i     = 1'b0;
    endtask

    // Issues one command, then runs ncyc cycles with the source always valid
    // and the chain always ready.
    //   mode 1: ack each transfer exactly two cycles after it happens.
    //   mode 0: ack in every cycle whose bit is set in ack_mask.
    // flush_i is pulsed in cycle flush_cyc. Use -1 for no flush.
    // Inputs are driven 1 time unit after the rising edge. Outputs are
    // sampled on the falling edge.
    task automatic run_cmd(input logic [15:0] len, input logic [3:0] id,
                           input int mode, input logic [63:0] ack_mask,
                           input int flush_cyc, input int ncyc);
        logic [1:0] pipe;
        int         src_idx;
        logic       xfer;
        pipe     = '0;
        src_idx  = 0;
        n_xfer   = 0;
        done_cnt = 0;
        done_cyc = -1;
        done_id  = '0;
        done_ab  = 1'b0;
        for (int c = 0; c < 64; c++) begin
            bcv[c]  = 1'b0;
            srdy[c] = 1'b0;
            cred[c] = '0;
        end
        idle_inputs();
        cmd_valid_i = 1'b1;
        cmd_len_i   = len;
        cmd_id_i    = id;
        @(negedge clk_i);
        acc_ready = cmd_ready_o;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            src_valid_i = 1'b1;
            bc_ready_i  = 1'b1;
            src_data_i  = DBASE + 64'(src_idx);
            tail_ack_i  = (mode == 1) ? pipe[1] : ack_mask[c];
            flush_i     = (c == flush_cyc);
            @(negedge clk_i);
            xfer    = bc_valid_o & bc_ready_i;
            bcv[c]  = bc_valid_o;
            srdy[c] = src_ready_o;
            cred[c] = dut.credits_q;
            if (xfer && n_xfer < 16) begin
                xfer_cyc[n_xfer]  = c;
                xfer_data[n_xfer] = bc_data_o;
                n_xfer++;
            end
            if (src_valid_i && src_ready_o) src_idx++;
            if (done_o) begin
                done_cnt++;
                done_cyc = c;
                done_id  = done_id_o;
                done_ab  = done_aborted_o;
            end
            pipe = {pipe[0], xfer};
            @(posedge clk_i);
            #1;
        end
        idle_inputs();
    endtask

    // Checks the output values while reset is held, then releases reset.
    task automatic test_reset();
        idle_inputs();
        src_data_i = 64'hDEAD_BEEF_0000_0001;
        rst_i      = 1'b1;
        #12;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (bc_valid_o !== 1'b0 || src_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_handshake: got bc_valid=%b src_ready=%b expected 0/0", bc_valid_o, src_ready_o); end
        checks++; if (bc_data_o !== 64'd0) begin errors++; $display("[TB] FAIL reset_bc_data: got %h expected 0", bc_data_o); end
        checks++; if (done_o !== 1'b0 || done_aborted_o !== 1'b0 || done_id_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_done: got done=%b ab=%b id=%0d expected 0/0/0", done_o, done_aborted_o, done_id_o); end
        checks++; if (credit_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_credit_err: got %b expected 0", credit_err_o); end
        checks++; if (dut.credits_q !== 3'd4) begin errors++; $display("[TB] FAIL reset_credits: got %0d expected 4", dut.credits_q); end
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        src_data_i = '0;
        @(posedge clk_i);
        #1;
    endtask

    // Three elements with acks following two cycles behind each transfer.
    task automatic test_basic();
        run_cmd(16'd3, 4'd5, 1, 64'd0, -1, 20);
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept: got %b expected 1", acc_ready); end
        checks++; if (n_xfer != 3) begin errors++; $display("[TB] FAIL basic_xfers: got %0d expected 3", n_xfer); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (xfer_data[k] !== DBASE + 64'(k)) begin errors++; $display("[TB] FAIL basic_data%0d: got %h expected %h", k, xfer_data[k], DBASE + 64'(k)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc != 5) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 5", done_cyc); end
        checks++; if (done_id !== 4'd5 || done_ab !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_tag: got id=%0d ab=%b expected 5/0", done_id, done_ab); end
        checks++; if (dut.credits_q !== 3'd4) begin errors++; $display("[TB] FAIL basic_credits_home: got %0d expected 4", dut.credits_q); end
    endtask

    // Six elements with no acks until cycle 10, then one ack every two cycles.
    task automatic test_credit_stall();
        logic [63:0] mask;
        mask = '0;
        for (int k = 0; k < 6; k++) mask[10 + 2 * k] = 1'b1;
        run_cmd(16'd6, 4'd2, 0, mask, -1, 30);
        checks++; if (n_xfer != 6) begin errors++; $display("[TB] FAIL stall_xfers: got %0d expected 6", n_xfer); end
        checks++; if (xfer_cyc[3] != 3) begin errors++; $display("[TB] FAIL stall_fourth_cycle: got %0d expected 3", xfer_cyc[3]); end
        checks++; if (bcv[4] !== 1'b0 || bcv[9] !== 1'b0) begin errors++; $display("[TB] FAIL stall_valid_low: got c4=%b c9=%b expected 0/0", bcv[4], bcv[9]); end
        checks++; if (xfer_cyc[4] != 11 || xfer_cyc[5] != 13) begin errors++; $display("[TB] FAIL stall_resume: got %0d,%0d expected 11,13", xfer_cyc[4], xfer_cyc[5]); end
        checks++; if (done_cyc != 21 || done_cnt != 1) begin errors++; $display("[TB] FAIL stall_done: got cycle=%0d count=%0d expected 21/1", done_cyc, done_cnt); end
        checks++; if (done_id !== 4'd2) begin errors++; $display("[TB] FAIL stall_done_id: got %0d expected 2", done_id); end
    endtask

    // An ack with zero credits refills one credit. An issue plus an ack with
    // one credit leaves the count at one.
    task automatic test_simultaneous();
        run_cmd(16'd5, 4'd3, 0, 64'h1F0, -1, 16);
        checks++; if (cred[4] !== 3'd0) begin errors++; $display("[TB] FAIL simul_zero_credits: got %0d expected 0", cred[4]); end
        checks++; if (cred[5] !== 3'd1) begin errors++; $display("[TB] FAIL simul_after_ack: got %0d expected 1", cred[5]); end
        checks++; if (n_xfer != 5 || xfer_cyc[4] != 5) begin errors++; $display("[TB] FAIL simul_issue: got n=%0d last=%0d expected 5/5", n_xfer, xfer_cyc[4]); end
        checks++; if (cred[6] !== 3'd1) begin errors++; $display("[TB] FAIL simul_issue_ack: got %0d expected 1", cred[6]); end
        checks++; if (done_cyc != 9) begin errors++; $display("[TB] FAIL simul_done_cycle: got %0d expected 9", done_cyc); end
        checks++; if (credit_err_o !== 1'b0) begin errors++; $display("[TB] FAIL simul_no_err: got %b expected 0", credit_err_o); end
    endtask

    // Flush after three transfers, then a clean command back to back.
    task automatic test_flush();
        int late_ready;
        run_cmd(16'd8, 4'd7, 1, 64'd0, 3, 20);
        late_ready = 0;
        for (int c = 3; c < 20; c++) if (srdy[c]) late_ready++;
        checks++; if (n_xfer != 3) begin errors++; $display("[TB] FAIL flush_xfers: got %0d expected 3", n_xfer); end
        checks++; if (late_ready != 0) begin errors++; $display("[TB] FAIL flush_src_ready: got %0d cycles expected 0", late_ready); end
        checks++; if (bcv[3] !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid_low: got %b expected 0", bcv[3]); end
        checks++; if (done_cyc != 5 || done_cnt != 1) begin errors++; $display("[TB] FAIL flush_done: got cycle=%0d count=%0d expected 5/1", done_cyc, done_cnt); end
        checks++; if (done_ab !== 1'b1 || done_id !== 4'd7) begin errors++; $display("[TB] FAIL flush_aborted: got ab=%b id=%0d expected 1/7", done_ab, done_id); end
        test_back_to_back();
    endtask

    // Command following a flushed one must complete normally.
    task automatic test_back_to_back();
        run_cmd(16'd2, 4'd1, 1, 64'd0, -1, 12);
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: got %b expected 1", acc_ready); end
        checks++; if (n_xfer != 2) begin errors++; $display("[TB] FAIL b2b_xfers: got %0d expected 2", n_xfer); end
        checks++; if (xfer_data[1] !== DBASE + 64'd1) begin errors++; $display("[TB] FAIL b2b_data: got %h expected %h", xfer_data[1], DBASE + 64'd1); end
        checks++; if (done_cyc != 4 || done_id !== 4'd1 || done_ab !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done: got cycle=%0d id=%0d ab=%b expected 4/1/0", done_cyc, done_id, done_ab); end
    endtask

    // Zero-length command, then a spurious ack while idle with full credits.
    task automatic test_zero_length();
        int any_valid;
        run_cmd(16'd0, 4'd9, 0, 64'd0, -1, 4);
        any_valid = 0;
        for (int c = 0; c < 4; c++) if (bcv[c]) any_valid++;
        checks++; if (done_cyc != 0 || done_cnt != 1) begin errors++; $display("[TB] FAIL zero_done: got cycle=%0d count=%0d expected 0/1", done_cyc, done_cnt); end
        checks++; if (done_id !== 4'd9 || done_ab !== 1'b0) begin errors++; $display("[TB] FAIL zero_tag: got id=%0d ab=%b expected 9/0", done_id, done_ab); end
        checks++; if (any_valid != 0 || n_xfer != 0) begin errors++; $display("[TB] FAIL zero_no_valid: got %0d valid cycles expected 0", any_valid); end
        @(negedge clk_i);
        checks++; if (credit_err_o !== 1'b0) begin errors++; $display("[TB] FAIL spur_before: got %b expected 0", credit_err_o); end
        @(posedge clk_i);
        #1;
        tail_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        tail_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if (credit_err_o !== 1'b1) begin errors++; $display("[TB] FAIL spur_set: got %b expected 1", credit_err_o); end
        checks++; if (dut.credits_q !== 3'd4) begin errors++; $display("[TB] FAIL spur_credits: got %0d expected 4", dut.credits_q); end
        repeat (5) @(posedge clk_i);
        #1;
        checks++; if (credit_err_o !== 1'b1) begin errors++; $display("[TB] FAIL spur_sticky: got %b expected 1", credit_err_o); end
    endtask

    // Reset asserted asynchronously while draining, then a fresh command.
    task automatic test_async_reset();
        run_cmd(16'd2, 4'd4, 0, 64'd0, -1, 3);
        checks++; if (busy_o !== 1'b1 || credit_err_o !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre: got busy=%b err=%b expected 1/1", busy_o, credit_err_o); end
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_state: got ready=%b busy=%b expected 1/0", cmd_ready_o, busy_o); end
        checks++; if (dut.credits_q !== 3'd4) begin errors++; $display("[TB] FAIL arst_credits: got %0d expected 4", dut.credits_q); end
        checks++; if (credit_err_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_err_clear: got %b expected 0", credit_err_o); end
        checks++; if (done_o !== 1'b0 || done_id_o !== 4'd0 || bc_valid_o !== 1'b0 || bc_data_o !== 64'd0) begin errors++; $display("[TB] FAIL arst_outputs: got done=%b id=%0d valid=%b data=%h expected 0", done_o, done_id_o, bc_valid_o, bc_data_o); end
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        run_cmd(16'd1, 4'd6, 1, 64'd0, -1, 8);
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_accept: got %b expected 1", acc_ready); end
        checks++; if (n_xfer != 1 || done_cyc != 3 || done_id !== 4'd6) begin errors++; $display("[TB] FAIL arst_next_cmd: got n=%0d cycle=%0d id=%0d expected 1/3/6", n_xfer, done_cyc, done_id); end
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_credit_stall();
        test_simultaneous();
        test_flush();
        test_zero_length();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bc_chain_sequencer.md
# bc_chain_sequencer

Sequencer at the head of the lane-to-lane broadcast operand chain used by the matmul datapath. It accepts a broadcast command (element count plus tag), streams that many 64-bit operands from the source operand port into lane 0 of the chain, and limits elements in flight to a credit budget. Credits return when the tail lane retires an element. It reports completion once every issued element has been retired by the tail, and supports abort via flush.

## Interface
- NrLanes, 4: lanes in the chain; informational only, bounds MaxOutstanding.
- MaxOutstanding, 4: credit budget, i.e. elements issued but not yet retired by the tail; legal range 1..2*NrLanes.
- CntWidth, 16: width of the element counter and cmd_len_i.
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when both this and cmd_valid_i are high.
- cmd_len_i  in  CntWidth  number of elements to broadcast.
- cmd_id_i  in  4  command tag, returned on done_id_o.
- src_valid_i  in  1  source operand valid.
- src_ready_o  out  1  source operand consumed.
- src_data_i  in  64  source operand (elen_t).
- bc_valid_o  out  1  chain head valid.
- bc_ready_i  in  1  chain head ready, from lane 0.
- bc_data_o  out  64  chain head data.
- tail_ack_i  in  1  one-cycle pulse: tail lane retired one element.
- flush_i  in  1  abort the current command.
- done_o  out  1  one-cycle completion pulse.
- done_id_o  out  4  tag of the completed command; valid with done_o.
- done_aborted_o  out  1  high with done_o if the command was flushed.
- busy_o  out  1  high in any state other than IDLE.
- credit_err_o  out  1  sticky; set on a tail_ack_i received while credits are full.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- Registers:
  - issued_q: CntWidth bits.
  - len_q: CntWidth bits.
  - id_q: 4 bits.
  - credits_q: $clog2(MaxOutstanding+1) bits; reset value MaxOutstanding.
  - aborted_q.
  - credit_err_q.
- IDLE:
  - cmd_ready_o=1.
  - On accept, capture len/id, clear issued_q and aborted_q.
  - Next state is ISSUE if cmd_len_i>0, otherwise DONE (zero-length command completes without touching the chain).
- ISSUE:
  - Pass-through: bc_data_o=src_data_i.
  - bc_valid_o = src_valid_i & (credits_q>0).
  - src_ready_o = bc_ready_i & (credits_q>0).
  - On transfer (bc_valid_o & bc_ready_i): issued_q+1, credits_q-1.
  - When the transfer makes issued_q equal len_q, go to DRAIN.
- DRAIN:
  - No issue.
  - When credits_q==MaxOutstanding (including an ack arriving that cycle that brings it to full), go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, with done_id_o=id_q and done_aborted_o=aborted_q.
  - Next state is IDLE.
- Credits:
  - tail_ack_i increments credits_q.
  - Issue and ack in the same cycle leave credits_q unchanged.
  - tail_ack_i with credits_q==MaxOutstanding and no same-cycle issue: credits_q holds and credit_err_q is set.
  - tail_ack_i is honoured in every state.
- flush_i:
  - In ISSUE: set aborted_q, go to DRAIN immediately. No transfer occurs in the flush cycle; bc_valid_o and src_ready_o are forced low.
  - In DRAIN: set aborted_q, remain in DRAIN.
  - In IDLE or DONE: ignored.
  - In-flight elements are never dropped; their acks are still collected.
- Outside ISSUE: bc_valid_o=0, src_ready_o=0, bc_data_o=0.

## Timing
- Reset (rst_i high, asynchronous):
  - state=IDLE, credits_q=MaxOutstanding, all other registers 0.
  - Outputs: cmd_ready_o=1; busy_o=0; bc_valid_o, src_ready_o, done_o, done_aborted_o and credit_err_o all 0; bc_data_o=0; done_id_o=0.
- Reset mid-command: everything returns to reset values the same cycle. Pending acks from before reset are not tracked.
- Data path: zero-latency combinational pass-through src to bc. Sustains 1 element/cycle while credits_q>0.
- Command accept to first possible transfer: 1 cycle (state ISSUE in the cycle after accept).
- Last tail_ack to done_o:
  - Last ack seen in DRAIN in cycle t gives DONE, and done_o, in t+1.
  - IDLE is reached in t+2; the next command can be accepted in t+2.
- Zero-length command: accepted in cycle t, done_o in t+1.
- Back-to-back commands: throughput limited by DRAIN. No overlap between commands.

## Test plan
- Basic command:
  - MaxOutstanding=4, cmd_len=3, id=5; src always valid, bc_ready always 1, tail_ack issued 2 cycles after each transfer.
  - Required: exactly 3 transfers with data in order; done_o pulses once with id=5, aborted=0; credits back at 4.
- Credit stall:
  - cmd_len=6, no tail_ack until cycle 10.
  - Required: bc_valid_o drops after 4 transfers; issue resumes one transfer per ack; done_o only after the 6th ack.
- Simultaneous events:
  - With credits=0, drive issue and tail_ack in the same cycle; then, with credits=1, drive issue and ack together.
  - Required: credits 1 stays at 1; no error.
- Zero-length and spurious ack:
  - Send cmd_len=0: done_o must pulse the cycle after accept with no bc_valid_o.
  - Then send tail_ack_i in IDLE with credits full: credit_err_o goes to 1 and stays 1 until reset.
- Flush:
  - cmd_len=8; assert flush_i after 3 transfers.
  - Required: no further src_ready_o; done_o with done_aborted_o=1 only after 3 acks.
  - A following command with len=2, id=1 completes with aborted=0.
- Async reset during DRAIN:
  - Required: outputs reach their reset values immediately and credits=MaxOutstanding.
  - A new command is accepted the cycle after rst_i falls.
